fifo_pack_reader: RTL and testbench

- Read-side master for the packet FIFO; the counterpart to the writer that fills it.
- Waits for the FIFO to report a full packet of NB_PACK words, then pops exactly NB_PACK words with the FIFO read acknowledge.
- Replays the packet on a downstream valid/ready stream with first/last framing.
- FIFO read data arrives one cycle after the pop, so the block tracks in-flight reads and buffers them in a 2-entry output buffer.

---
 rtl/fifo_pack_reader_pkg.sv | 18 +
 rtl/pack_out_buf.sv | 44 ++++
 rtl/fifo_pack_reader.sv | 128 ++++++++++++
 tb/tb_fifo_pack_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pack_reader_pkg.sv
// Shared types for the packet FIFO read master: FSM states and output buffer entries.
package fifo_pack_reader_pkg;

  localparam int BUF_DEPTH       = 2;
  localparam int ENTRY_DATA_SIZE = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic [ENTRY_DATA_SIZE-1:0] data;
    logic                       first;
    logic                       last;
  } entry_t;

endpackage

// File: rtl/pack_out_buf.sv
// Two-entry FIFO of framed words sitting between the FIFO read pipe and the output stream.
module pack_out_buf
  import fifo_pack_reader_pkg::*;
#(
  parameter type ENTRY_T = entry_t
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       push,
  input  ENTRY_T     entry_in,
  input  logic       pop,
  output ENTRY_T     head,
  output logic [1:0] occ
);

  ENTRY_T     r_mem [BUF_DEPTH];
  logic       r_head_ptr;
  logic       r_tail_ptr;
  logic [1:0] r_occ;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_head_ptr <= 1'b0;
      r_tail_ptr <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_tail_ptr] <= entry_in;
        r_tail_ptr        <= ~r_tail_ptr;
      end
      if (pop) r_head_ptr <= ~r_head_ptr;
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head = r_mem[r_head_ptr];
  assign occ  = r_occ;

endmodule

// File: rtl/fifo_pack_reader.sv
// Pops NB_PACK-word packets from the packet FIFO and replays them as a framed valid/ready stream.
// Optional stall counter output enabled by defining FIFO_PACK_READER_STALL_CNT_EN.
module fifo_pack_reader
  import fifo_pack_reader_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int NB_PACK   = 8,
  parameter int CNT_SIZE  = 4
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic [DATA_SIZE-1:0] fifo_data_out,
  input  logic                 fifo_empty,
  input  logic                 fifo_nb_pack_available,
  output logic                 fifo_r_ack,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy
`ifdef FIFO_PACK_READER_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_SIZE-1:0] data;
    logic                 first;
    logic                 last;
  } entry_w_t;

  localparam logic [CNT_SIZE-1:0] LAST_CNT = CNT_SIZE'(NB_PACK - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_SIZE-1:0] r_cnt;
  logic [CNT_SIZE-1:0] w_cnt_nxt;
  logic                r_inflight_p1;
  logic                r_first_p1;
  logic                r_last_p1;
  logic [1:0]          w_occ;
  logic                w_xfer;
  logic                w_pop;
  logic                w_credit_ok;
  entry_w_t            w_entry_in;
  entry_w_t            w_head;

  // A word leaving this cycle frees its slot, which keeps one pop per cycle sustainable.
  assign w_xfer      = out_valid & out_ready;
  assign w_credit_ok = (w_occ - {1'b0, w_xfer} + {1'b0, r_inflight_p1}) < 2'd2;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (fifo_nb_pack_available) begin
          w_state_nxt = BURST;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        w_pop = !fifo_empty && w_credit_ok;
        if (w_pop) begin
          w_cnt_nxt = r_cnt + CNT_SIZE'(1);
          if (r_cnt == LAST_CNT) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pop stage -> capture stage: framing tags follow the word through the read latency.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_inflight_p1 <= 1'b0;
      r_first_p1    <= 1'b0;
      r_last_p1     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_inflight_p1 <= w_pop;
      r_first_p1    <= (r_cnt == '0);
      r_last_p1     <= (r_cnt == LAST_CNT);
    end
  end

  assign w_entry_in = '{data: fifo_data_out, first: r_first_p1, last: r_last_p1};

  pack_out_buf #(
    .ENTRY_T (entry_w_t)
  ) u_buf (
    .clk      (clk),
    .nRST     (nRST),
    .push     (r_inflight_p1),
    .entry_in (w_entry_in),
    .pop      (w_xfer),
    .head     (w_head),
    .occ      (w_occ)
  );

  assign fifo_r_ack = w_pop;
  assign out_valid  = (w_occ != 2'd0);
  assign out_data   = w_head.data;
  assign out_first  = w_head.first & out_valid;
  assign out_last   = w_head.last & out_valid;
  assign busy       = (r_state == BURST);

`ifdef FIFO_PACK_READER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= 16'd0;
    end else if ((r_state == BURST) && fifo_empty && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Bench for fifo_pack_reader: behavioural FIFO, stream-order model and directed packet scenarios.
module tb_fifo_pack_reader;

  localparam int DW  = 32;
  localparam int NBP = 8;
  localparam int CW  = 4;

  logic          clk  = 1'b0;
  logic          nRST = 1'b0;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_empty;
  logic          fifo_nb_pack_available;
  logic          fifo_r_ack;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_first;
  logic          out_last;
  logic          busy;
`ifdef FIFO_PACK_READER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   stall0;
`endif

  // FIFO model: fmem holds every word ever loaded; frd counts pops, fwr counts loads.
  logic [DW-1:0] fmem [0:255];
  int            fwr = 0;
  int            frd = 0;
  logic          force_empty = 1'b0;
  logic          avail_en    = 1'b0;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            exp_idx = 0;
  int            n_out   = 0;
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_word  = '0;
  int            base;
  int            k;

  always #5 clk = ~clk;

  assign fifo_empty             = force_empty || (frd == fwr);
  assign fifo_nb_pack_available = avail_en && ((fwr - frd) >= NBP);

  fifo_pack_reader #(
    .DATA_SIZE (DW),
    .NB_PACK   (NBP),
    .CNT_SIZE  (CW)
  ) u_dut (
    .clk                    (clk),
    .nRST                   (nRST),
    .fifo_data_out          (fifo_data_out),
    .fifo_empty             (fifo_empty),
    .fifo_nb_pack_available (fifo_nb_pack_available),
    .fifo_r_ack             (fifo_r_ack),
    .out_data               (out_data),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out_first              (out_first),
    .out_last               (out_last),
    .busy                   (busy)
`ifdef FIFO_PACK_READER_STALL_CNT_EN
    ,
    .stall_cnt              (stall_cnt)
`endif
  );

  always @(posedge clk) begin
    if (fifo_r_ack) begin
      fifo_data_out <= fmem[frd[7:0]];
      frd           <= frd + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: after any reset, the output must replay the FIFO contents from the
  // next unpopped word, in order, framed in groups of NBP counted from that point.
  always @(negedge clk) begin
    if (!nRST) begin
      exp_idx    = frd;
      n_out      = 0;
      prev_stall = 1'b0;
    end else begin
      check("occ_bound", u_dut.w_occ <= 2'd2, 1);
      check("ack_outside_burst", fifo_r_ack && !busy, 0);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", {out_data, out_first, out_last}, prev_word);
      end
      if (out_valid) begin
        check("stream_data", out_data, fmem[exp_idx[7:0]]);
        check("stream_first", out_first, (n_out % NBP) == 0);
        check("stream_last", out_last, (n_out % NBP) == NBP - 1);
        if (out_ready) begin
          exp_idx++;
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_data, out_first, out_last};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] first_word, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[fwr[7:0]] = first_word + DW'(i);
      fwr = fwr + 1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (!(exp_idx == fwr && !busy && !out_valid) && cyc < budget) begin
      tick(1);
      cyc++;
    end
    check(name, cyc < budget, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    check("rst_r_ack", fifo_r_ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_first", out_first, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    nRST = 1'b1;
    tick(2);

    // Single packet, sink always ready: pops and outputs on consecutive cycles.
    out_ready = 1'b1;
    avail_en  = 1'b1;
    base      = frd;
    load(32'h10, 8);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t1_ack", fifo_r_ack, i < 8);
      check("t1_busy", busy, i < 8);
      check("t1_valid", out_valid, i >= 2);
      if (i >= 2) begin
        check("t1_data", out_data, 32'h10 + DW'(i) - 32'd2);
        check("t1_first", out_first, i == 2);
        check("t1_last", out_last, i == 9);
      end
    end
    drain("t1_drain", 20);
    check("t1_pops", frd - base, 8);

    // Sink stalled for 5 cycles: only two pops fit before credits run out.
    out_ready = 1'b0;
    base      = frd;
    load(32'h10, 8);
    tick(5);
    check("t2_pops_stalled", frd - base, 2);
    check("t2_valid", out_valid, 1);
    check("t2_head_data", out_data, 32'h10);
    check("t2_head_first", out_first, 1);
    out_ready = 1'b1;
    drain("t2_drain", 40);
    check("t2_pops", frd - base, 8);
    check("t2_delivered", exp_idx, fwr);

    // FIFO runs dry after the third pop for four cycles.
    base = frd;
`ifdef FIFO_PACK_READER_STALL_CNT_EN
    stall0 = stall_cnt;
`endif
    load(32'h10, 8);
    tick(4);
    check("t3_three_pops", frd - base, 3);
    force_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_no_ack", fifo_r_ack, 0);
      check("t3_cnt_hold", u_dut.r_cnt, 3);
      check("t3_busy", busy, 1);
      tick(1);
    end
`ifdef FIFO_PACK_READER_STALL_CNT_EN
    check("t3_stall_cnt", stall_cnt - stall0, 4);
`endif
    force_empty = 1'b0;
    drain("t3_drain", 40);
    check("t3_pops", frd - base, 8);

    // Two packets queued back to back.
    base = frd;
    load(32'h40, 16);
    drain("t4_drain", 80);
    check("t4_pops", frd - base, 16);
    check("t4_delivered", exp_idx, fwr);

    // Reset after the fourth pop: the partial packet is dropped.
    base = frd;
    load(32'h50, 8);
    tick(5);
    check("t5_four_pops", frd - base, 4);
    nRST = 1'b0;
    #1;
    check("t5_r_ack", fifo_r_ack, 0);
    check("t5_valid", out_valid, 0);
    check("t5_first", out_first, 0);
    check("t5_last", out_last, 0);
    check("t5_data", out_data, 0);
    check("t5_busy", busy, 0);
    check("t5_state", u_dut.r_state, 0);
`ifdef FIFO_PACK_READER_STALL_CNT_EN
    check("t5_stall_clr", stall_cnt, 0);
`endif
    tick(1);
    nRST = 1'b1;
    load(32'h58, 4);
    k = 0;
    while (!out_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("t5_restart_seen", k < 20, 1);
    check("t5_restart_data", out_data, 32'h54);
    check("t5_restart_first", out_first, 1);
    drain("t5_drain", 40);
    check("t5_delivered", exp_idx, fwr);

    // Sink toggling every cycle across a whole packet.
    out_ready = 1'b0;
    base      = frd;
    load(32'h60, 8);
    k = 0;
    while (!(exp_idx == fwr && !busy && !out_valid) && k < 60) begin
      tick(1);
      out_ready = ~out_ready;
      k++;
    end
    check("t6_drain", k < 60, 1);
    check("t6_pops", frd - base, 8);
    check("t6_delivered", exp_idx, fwr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
